// File: rtl/biss_read_scheduler.sv
// BiSS-C read scheduler: periodic/one-shot frame requests,
// timeout supervision, bounded retries and sticky fault.
module biss_read_scheduler #(
    parameter int POS_W       = 26,
    parameter int PERIOD_CYC  = 20000,
    parameter int TIMEOUT_CYC = 4000,
    parameter int GAP_CYC     = 400,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             oneshot,
    input  logic             clr_fault,
    output logic             rd_req,
    input  logic             frm_done,
    input  logic             frm_crc_ok,
    input  logic [1:0]       frm_err,
    input  logic [POS_W-1:0] frm_pos,
    output logic [POS_W-1:0] pos_out,
    output logic             pos_valid,
    output logic             enc_err,
    output logic             enc_warn,
    output logic             busy,
    output logic             fault,
    output logic [15:0]      crc_fail_cnt,
    output logic [15:0]      timeout_cnt
);

    localparam int PER_W = $clog2(PERIOD_CYC);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int RT_W  = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]       state;
    logic [PER_W-1:0] per_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [RT_W-1:0]  retry_cnt;
    logic             pend;
    logic             ok;
    logic             tick;
    logic             take;
    logic             to_hit;
    logic             gap_end;

    assign tick    = enable && (per_cnt == PER_W'(PERIOD_CYC - 1));
    assign take    = (state == S_IDLE) && (pend || (oneshot && !enable));
    assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign gap_end = (gap_cnt == GAP_W'(GAP_CYC - 1));

    assign rd_req = (state == S_REQ);
    assign busy   = (state == S_REQ) || (state == S_WAIT) ||
                    (state == S_GAP);
    assign fault  = (state == S_FAULT);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            per_cnt <= '0;
        end else if (tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // One-deep request latch; a tick beats a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst || !enable || state == S_FAULT) begin
            pend <= 1'b0;
        end else if (tick) begin
            pend <= 1'b1;
        end else if (take) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            retry_cnt    <= '0;
            ok           <= 1'b0;
            pos_out      <= '0;
            pos_valid    <= 1'b0;
            enc_err      <= 1'b0;
            enc_warn     <= 1'b0;
            crc_fail_cnt <= '0;
            timeout_cnt  <= '0;
        end else begin
            pos_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        state     <= S_REQ;
                        retry_cnt <= '0;
                    end
                end
                S_REQ: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (frm_done) begin
                        ok      <= frm_crc_ok;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                        if (frm_crc_ok) begin
                            pos_out   <= frm_pos;
                            pos_valid <= 1'b1;
                            enc_err   <= ~frm_err[1];
                            enc_warn  <= ~frm_err[0];
                            retry_cnt <= '0;
                        end else if (crc_fail_cnt != 16'hFFFF) begin
                            crc_fail_cnt <= crc_fail_cnt + 16'd1;
                        end
                    end else if (to_hit) begin
                        ok      <= 1'b0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (!gap_end) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else if (ok) begin
                        state <= S_IDLE;
                    end else if (retry_cnt < RT_W'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= S_REQ;
                    end else begin
                        state <= S_FAULT;
                    end
                end
                S_FAULT: begin
                    if (clr_fault) begin
                        retry_cnt <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biss_read_scheduler.sv
// Bench for biss_read_scheduler: directed table/sequences plus
// randomized traffic against a deadline-based reference model.
module tb_biss_read_scheduler;

    localparam int PW  = 26;
    localparam int PER = 100;
    localparam int TO  = 40;
    localparam int GAP = 10;
    localparam int MR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          oneshot;
    logic          clr_fault;
    logic          rd_req;
    logic          frm_done;
    logic          frm_crc_ok;
    logic [1:0]    frm_err;
    logic [PW-1:0] frm_pos;
    logic [PW-1:0] pos_out;
    logic          pos_valid;
    logic          enc_err;
    logic          enc_warn;
    logic          busy;
    logic          fault;
    logic [15:0]   crc_fail_cnt;
    logic [15:0]   timeout_cnt;

    biss_read_scheduler #(
        .POS_W(PW), .PERIOD_CYC(PER), .TIMEOUT_CYC(TO),
        .GAP_CYC(GAP), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .oneshot(oneshot),
        .clr_fault(clr_fault), .rd_req(rd_req), .frm_done(frm_done),
        .frm_crc_ok(frm_crc_ok), .frm_err(frm_err), .frm_pos(frm_pos),
        .pos_out(pos_out), .pos_valid(pos_valid), .enc_err(enc_err),
        .enc_warn(enc_warn), .busy(busy), .fault(fault),
        .crc_fail_cnt(crc_fail_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_REQ, M_WAIT, M_GAP, M_FAULT} ph_t;
    ph_t           m_ph;
    bit            m_pend;
    int            m_retry;
    bit            m_ok;
    logic [PW-1:0] m_pos;
    bit            m_pv;
    bit            m_ee;
    bit            m_ew;
    int            m_crc;
    int            m_to;
    int            m_deadline;
    int            m_gap_end;
    int            en_since;
    bit            model_on = 0;

    always @(posedge clk) begin
        bit tick;
        bit take;
        if (rst) begin
            m_ph = M_IDLE; m_pend = 0; m_retry = 0; m_ok = 0;
            m_pos = '0; m_pv = 0; m_ee = 0; m_ew = 0;
            m_crc = 0; m_to = 0; en_since = cyc + 1;
        end else begin
            tick = enable && ((cyc - en_since) % PER == PER - 1);
            take = (m_ph == M_IDLE) && (m_pend || (oneshot && !enable));
            if (!enable || m_ph == M_FAULT) m_pend = 0;
            else if (tick) m_pend = 1;
            else if (take) m_pend = 0;
            if (!enable) en_since = cyc + 1;
            m_pv = 0;
            case (m_ph)
                M_IDLE: if (take) begin
                    m_ph = M_REQ; m_retry = 0;
                end
                M_REQ: begin
                    m_ph = M_WAIT; m_deadline = cyc + TO;
                end
                M_WAIT: begin
                    if (frm_done) begin
                        m_ok = frm_crc_ok;
                        if (frm_crc_ok) begin
                            m_pos = frm_pos; m_pv = 1;
                            m_ee = !frm_err[1]; m_ew = !frm_err[0];
                        end else if (m_crc < 65535) m_crc++;
                        m_ph = M_GAP; m_gap_end = cyc + GAP;
                    end else if (cyc == m_deadline) begin
                        m_ok = 0;
                        if (m_to < 65535) m_to++;
                        m_ph = M_GAP; m_gap_end = cyc + GAP;
                    end
                end
                M_GAP: if (cyc == m_gap_end) begin
                    if (m_ok) m_ph = M_IDLE;
                    else if (m_retry < MR) begin
                        m_retry++; m_ph = M_REQ;
                    end else m_ph = M_FAULT;
                end
                M_FAULT: if (clr_fault) begin
                    m_ph = M_IDLE; m_retry = 0;
                end
                default: m_ph = M_IDLE;
            endcase
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic [63:0] e;
        logic [63:0] a;
        if (model_on) begin
            e = {m_ph == M_REQ,
                 m_ph == M_REQ || m_ph == M_WAIT || m_ph == M_GAP,
                 m_ph == M_FAULT, m_pv, m_ee, m_ew, m_pos,
                 16'(m_crc), 16'(m_to)};
            a = {rd_req, busy, fault, pos_valid, enc_err, enc_warn,
                 pos_out, crc_fail_cnt, timeout_cnt};
            chk($sformatf("model@%0d", cyc), a, e);
        end
    end

    // ---------------- monitor ----------------
    int req_q[$];
    int n_pv = 0;

    always @(negedge clk) begin
        if (rd_req === 1'b1) req_q.push_back(cyc);
        if (pos_valid === 1'b1) n_pv++;
    end

    // ---------------- encoder responder ----------------
    bit            resp_on   = 0;
    bit            resp_rand = 0;
    int            resp_dly  = 20;
    int            resp_fail_n = 0;
    logic [1:0]    resp_err  = 2'b11;
    logic [PW-1:0] resp_pos  = '0;
    bit            armed     = 0;
    int            resp_at   = 0;

    always @(negedge clk) begin
        if (rd_req === 1'b1 && resp_on) begin
            armed   = 1;
            resp_at = cyc + (resp_rand ? int'($urandom_range(TO + 6, 1))
                                       : resp_dly);
        end
        frm_done = 1'b0;
        if (armed && cyc == resp_at) begin
            armed    = 0;
            frm_done = 1'b1;
            if (resp_rand) begin
                frm_crc_ok = ($urandom % 4) != 0;
                frm_err    = 2'($urandom);
                frm_pos    = PW'($urandom);
            end else begin
                frm_crc_ok = (resp_fail_n == 0);
                if (resp_fail_n > 0) resp_fail_n--;
                frm_err = resp_err;
                frm_pos = resp_pos;
            end
        end else if (resp_rand && ($urandom % 200) == 0) begin
            frm_done   = 1'b1;
            frm_crc_ok = 1'($urandom);
            frm_err    = 2'($urandom);
            frm_pos    = PW'($urandom);
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_oneshot();
        oneshot = 1'b1;
        @(negedge clk);
        oneshot = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_pos"}, pos_out, 0);
        chk({tag, "_pv"}, pos_valid, 0);
        chk({tag, "_err"}, {enc_err, enc_warn}, 0);
        chk({tag, "_crc"}, crc_fail_cnt, 0);
        chk({tag, "_to"}, timeout_cnt, 0);
    endtask

    typedef struct {
        logic [1:0]    err;
        int            dly;
        logic [PW-1:0] pos;
        bit            ee;
        bit            ew;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int pv0;
        int n;
        tbl[0] = '{2'b01, 20,     26'h0000001, 1'b1, 1'b0};
        tbl[1] = '{2'b11, 20,     26'h3FFFFFF, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 5,      26'h1555555, 1'b0, 1'b1};
        tbl[3] = '{2'b00, TO,     26'h0ABCDEF, 1'b1, 1'b1};
        tbl[4] = '{2'b11, TO - 1, 26'h2000000, 1'b0, 1'b0};

        rst = 1'b1; enable = 1'b0; oneshot = 1'b0; clr_fault = 1'b0;
        frm_done = 1'b0; frm_crc_ok = 1'b0;
        frm_err = 2'b11; frm_pos = '0;
        repeat (3) @(negedge clk);
        model_on = 1;
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // periodic polling
        resp_on = 1; resp_dly = 20; resp_err = 2'b11;
        resp_pos = 26'h2A5A5A5;
        req_q.delete(); pv0 = n_pv;
        enable = 1'b1;
        repeat (350) @(negedge clk);
        chk("t1_nreq", req_q.size(), 3);
        for (int i = 1; i < req_q.size(); i++)
            chk("t1_period", req_q[i] - req_q[i-1], PER);
        chk("t1_npv", n_pv - pv0, req_q.size());
        chk("t1_pos", pos_out, 26'h2A5A5A5);
        enable = 1'b0;
        wait_idle("t1", 200);

        // two CRC failures then success
        resp_fail_n = 2; resp_pos = 26'h1234567;
        req_q.delete(); pv0 = n_pv;
        pulse_oneshot();
        wait_idle("t2", 300);
        chk("t2_nreq", req_q.size(), 3);
        for (int i = 1; i < req_q.size(); i++)
            chk("t2_space", req_q[i] - req_q[i-1], 1 + 20 + GAP);
        chk("t2_crc", crc_fail_cnt, 2);
        chk("t2_npv", n_pv - pv0, 1);
        chk("t2_fault", fault, 0);

        // silent encoder -> retries exhausted -> fault
        resp_on = 0;
        req_q.delete();
        pulse_oneshot();
        n = 0;
        while (!fault && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t3_nreq", req_q.size(), MR + 1);
        for (int i = 1; i < req_q.size(); i++)
            chk("t3_space", req_q[i] - req_q[i-1], 1 + TO + GAP);
        chk("t3_to", timeout_cnt, 4);
        chk("t3_fault", fault, 1);
        chk("t3_busy", busy, 0);
        chk("t3_pos", pos_out, 26'h1234567);
        enable = 1'b1;
        req_q.delete();
        repeat (250) @(negedge clk);
        chk("t3_noreq", req_q.size(), 0);
        chk("t3_sticky", fault, 1);
        resp_on = 1;
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        req_q.delete();
        n = 0;
        while (req_q.size() == 0 && n < PER + 5) begin
            @(negedge clk);
            n++;
        end
        chk("t3_clr_req", req_q.size(), 1);
        enable = 1'b0;
        wait_idle("t3", 200);

        // flag decode and timeout-edge table
        for (int i = 0; i < 5; i++) begin
            resp_err = tbl[i].err; resp_dly = tbl[i].dly;
            resp_pos = tbl[i].pos;
            pv0 = n_pv;
            pulse_oneshot();
            wait_idle($sformatf("tbl%0d", i), 200);
            chk($sformatf("tbl%0d_pos", i), pos_out, tbl[i].pos);
            chk($sformatf("tbl%0d_ee", i), enc_err, tbl[i].ee);
            chk($sformatf("tbl%0d_ew", i), enc_warn, tbl[i].ew);
            chk($sformatf("tbl%0d_npv", i), n_pv - pv0, 1);
            chk($sformatf("tbl%0d_to", i), timeout_cnt, 4);
        end

        // reset while waiting for a frame
        resp_on = 0;
        req_q.delete();
        enable = 1'b1;
        n = 0;
        while (req_q.size() == 0 && n < PER + 5) begin
            @(negedge clk);
            n++;
        end
        chk("t6_req", req_q.size(), 1);
        repeat (5) @(negedge clk);
        chk("t6_inwait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t6");
        rst = 1'b0;
        req_q.delete();
        n = 0;
        while (req_q.size() == 0 && n < PER + 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first", (n >= PER && n <= PER + 2), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;

        // randomized traffic
        resp_on = 1; resp_rand = 1;
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 300) == 0) enable = !enable;
            oneshot   = ($urandom % 40) == 0;
            clr_fault = ($urandom % 60) == 0;
            rst       = ($urandom % 1500) == 0;
            @(negedge clk);
        end
        rst = 1'b0; oneshot = 1'b0; clr_fault = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
